// File: rtl/ifu_pkg.sv
// rtl/ifu_pkg.sv - shared types and constants for the instruction fetch unit
package ifu_pkg;

    localparam int XLEN        = 32;
    localparam int INSTR_BYTES = 4;

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_DROP
    } ifu_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } ifu_entry_t;

    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return {pc[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifu_fifo.sv
// rtl/ifu_fifo.sv - instruction buffer: pc/instr entries with push, pop and flush (flush wins)
module ifu_fifo
    import ifu_pkg::*;
#(
    parameter int  DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  ifu_entry_t       push_data_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output ifu_entry_t       head_o,
    output logic [CNT_W-1:0] count_o
);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    ifu_entry_t       mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign do_push = push_i && (count_q != FULL_CNT);
    assign do_pop  = pop_i && (count_q != '0);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - fetch stage: PC, single-outstanding imem requests, decode buffer, redirect flush
// Optional IFU_PERF_CNT_EN adds fetch/drop performance counter outputs.
module instr_fetch_unit
    import ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    input  logic        instr_ready_i
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetch_cnt_o,
    output logic [31:0] perf_drop_cnt_o
`endif
);

    localparam int               CNT_W    = $clog2(BUF_DEPTH) + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BUF_DEPTH);

    ifu_state_e       state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      req_pc_q;
    logic             req;
    logic             push;
    logic             pop;
    logic             drop_rsp;
    logic [CNT_W-1:0] count;
    ifu_entry_t       head;
    ifu_entry_t       push_entry;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= S_REQ;
            pc_q     <= RESET_PC;
            req_pc_q <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            if (req && imem_gnt_i) begin
                req_pc_q <= pc_q;
            end
        end
    end

    // A redirect with the response already on the bus consumes it, so no DROP wait is needed.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req      = 1'b0;
        push     = 1'b0;
        drop_rsp = 1'b0;
        case (state_q)
            S_REQ: begin
                req = !rst_i && (count < FULL_CNT) && !redirect_i;
                if (req && imem_gnt_i) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rvalid_i) begin
                    state_d  = S_REQ;
                    push     = !redirect_i;
                    drop_rsp = redirect_i;
                end else if (redirect_i) begin
                    state_d = S_DROP;
                end
            end
            S_DROP: begin
                if (imem_rvalid_i) begin
                    state_d  = S_REQ;
                    drop_rsp = 1'b1;
                end
            end
            default: state_d = S_REQ;
        endcase
        if (redirect_i) begin
            pc_d = align_pc(redirect_pc_i);
        end else if (req && imem_gnt_i) begin
            pc_d = pc_q + 32'(INSTR_BYTES);
        end
    end

    assign push_entry.pc    = req_pc_q;
    assign push_entry.instr = imem_rdata_i;
    assign pop              = instr_valid_o && instr_ready_i;

    ifu_fifo #(
        .DEPTH(BUF_DEPTH)
    ) u_fifo (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .push_i     (push),
        .push_data_i(push_entry),
        .pop_i      (pop),
        .flush_i    (redirect_i),
        .head_o     (head),
        .count_o    (count)
    );

    assign imem_req_o    = req;
    assign imem_addr_o   = pc_q;
    assign instr_valid_o = (count != '0);
    assign instr_o       = head.instr;
    assign instr_pc_o    = head.pc;

`ifdef IFU_PERF_CNT_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] drop_cnt_q;
    logic [31:0] flushed;

    // A head popped in the redirect cycle was delivered, not flushed.
    assign flushed = redirect_i ? (32'(count) - 32'(pop)) : 32'd0;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fetch_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_q + 32'(pop);
            drop_cnt_q  <= drop_cnt_q + flushed + 32'(drop_rsp);
        end
    end

    assign perf_fetch_cnt_o = fetch_cnt_q;
    assign perf_drop_cnt_o  = drop_cnt_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - per-cycle vector table plus PC-wrap sequence for instr_fetch_unit
module tb_instr_fetch_unit;

    typedef struct {
        logic        rst;
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
        logic        redir;
        logic [31:0] rpc;
        logic        rdy;
        logic        ereq;
        logic [31:0] eaddr;
        logic        evalid;
        logic        chk;
        logic [31:0] einstr;
        logic [31:0] epc;
    } vec_t;

    localparam logic [31:0] I_A = 32'h0050_0093;
    localparam logic [31:0] I_B = 32'h00a0_0113;
    localparam logic [31:0] I_C = 32'h00f0_0193;
    localparam logic [31:0] I_D = 32'h0140_0213;
    localparam logic [31:0] I_E = 32'h0190_0293;
    localparam logic [31:0] I_F = 32'h01e0_0313;
    localparam logic [31:0] I_G = 32'h0640_0393;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        gnt, rv, redir, rdy, req, valid;
    logic [31:0] rdata, rpc, addr, instr, ipc;
    logic        w_gnt, w_rv, w_redir, w_rdy, w_req, w_valid;
    logic [31:0] w_rdata, w_rpc, w_addr, w_instr, w_ipc;
`ifdef IFU_PERF_CNT_EN
    logic [31:0] fetch_cnt, drop_cnt, w_fetch_cnt, w_drop_cnt;
    int          perf_idx;
`endif

    int   total  = 0;
    int   passed = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    instr_fetch_unit #(.RESET_PC(32'h0000_0100), .BUF_DEPTH(2)) dut (
        .clk_i(clk), .rst_i(rst),
        .imem_req_o(req), .imem_addr_o(addr), .imem_gnt_i(gnt),
        .imem_rvalid_i(rv), .imem_rdata_i(rdata),
        .redirect_i(redir), .redirect_pc_i(rpc),
        .instr_valid_o(valid), .instr_o(instr), .instr_pc_o(ipc), .instr_ready_i(rdy)
`ifdef IFU_PERF_CNT_EN
        , .perf_fetch_cnt_o(fetch_cnt), .perf_drop_cnt_o(drop_cnt)
`endif
    );

    instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .BUF_DEPTH(2)) dut_w (
        .clk_i(clk), .rst_i(rst),
        .imem_req_o(w_req), .imem_addr_o(w_addr), .imem_gnt_i(w_gnt),
        .imem_rvalid_i(w_rv), .imem_rdata_i(w_rdata),
        .redirect_i(w_redir), .redirect_pc_i(w_rpc),
        .instr_valid_o(w_valid), .instr_o(w_instr), .instr_pc_o(w_ipc), .instr_ready_i(w_rdy)
`ifdef IFU_PERF_CNT_EN
        , .perf_fetch_cnt_o(w_fetch_cnt), .perf_drop_cnt_o(w_drop_cnt)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic add(input logic r, input logic g, input logic v, input logic [31:0] d,
                       input logic rd, input logic [31:0] rp, input logic ry,
                       input logic eq, input logic [31:0] ea, input logic ev,
                       input logic ck, input logic [31:0] ei, input logic [31:0] ep);
        vec_t x;
        x.rst = r; x.gnt = g; x.rv = v; x.rdata = d; x.redir = rd; x.rpc = rp; x.rdy = ry;
        x.ereq = eq; x.eaddr = ea; x.evalid = ev; x.chk = ck; x.einstr = ei; x.epc = ep;
        vecs.push_back(x);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t v;
        int   waited;
        gnt = 0; rv = 0; rdata = 0; redir = 0; rpc = 0; rdy = 0;
        w_gnt = 0; w_rv = 0; w_rdata = 0; w_redir = 0; w_rpc = 0; w_rdy = 0;

        // rst gnt rv rdata redir rpc rdy | req addr valid chk instr pc
        // streaming, gnt=1, rvalid the cycle after gnt, ready=1
        add(1,0,0,0,0,0,1,       0,32'h100,0,1,0,0);
        add(0,1,0,0,0,0,1,       1,32'h100,0,0,0,0);
        add(0,1,1,I_A,0,0,1,     0,32'h104,0,0,0,0);
        add(0,1,0,0,0,0,1,       1,32'h104,1,1,I_A,32'h100);
        add(0,1,1,I_B,0,0,1,     0,32'h108,0,0,0,0);
        add(0,1,0,0,0,0,1,       1,32'h108,1,1,I_B,32'h104);
        add(0,1,1,I_C,0,0,1,     0,32'h10c,0,0,0,0);
        add(0,0,0,0,0,0,1,       1,32'h10c,1,1,I_C,32'h108);
        // backpressure fills the buffer, one pop reopens requests
        add(1,0,0,0,0,0,0,       0,32'h100,0,1,0,0);
        add(0,1,0,0,0,0,0,       1,32'h100,0,0,0,0);
        add(0,0,1,I_A,0,0,0,     0,32'h104,0,0,0,0);
        add(0,1,0,0,0,0,0,       1,32'h104,1,1,I_A,32'h100);
        add(0,0,1,I_B,0,0,0,     0,32'h108,1,1,I_A,32'h100);
        add(0,1,0,0,0,0,0,       0,32'h108,1,1,I_A,32'h100);
        add(0,1,0,0,0,0,1,       0,32'h108,1,1,I_A,32'h100);
        add(0,1,0,0,0,0,0,       1,32'h108,1,1,I_B,32'h104);
        // redirect in WAIT, late response discarded
        add(0,0,0,0,1,32'h200,0, 0,32'h10c,1,1,I_B,32'h104);
        add(0,0,0,0,0,0,0,       0,32'h200,0,0,0,0);
        add(0,0,0,0,0,0,0,       0,32'h200,0,0,0,0);
        add(0,0,1,32'hDEADBEEF,0,0,0, 0,32'h200,0,0,0,0);
        add(0,1,0,0,0,0,1,       1,32'h200,0,0,0,0);
        add(0,0,1,I_C,0,0,1,     0,32'h204,0,0,0,0);
        add(0,0,0,0,0,0,0,       1,32'h204,1,1,I_C,32'h200);
        // redirect coincident with rvalid and pop
        add(0,1,0,0,0,0,0,       1,32'h204,1,1,I_C,32'h200);
        add(0,0,1,I_D,1,32'h300,1, 0,32'h208,1,1,I_C,32'h200);
        add(0,1,0,0,0,0,0,       1,32'h300,0,0,0,0);
        add(0,0,1,I_E,0,0,0,     0,32'h304,0,0,0,0);
        add(0,1,0,0,0,0,0,       1,32'h304,1,1,I_E,32'h300);
        add(0,0,1,I_F,0,0,0,     0,32'h308,1,1,I_E,32'h300);
        // full buffer: redirect with pop, low PC bits cleared; then redirect in REQ blocks req
        add(0,1,0,0,1,32'h403,1, 0,32'h308,1,1,I_E,32'h300);
        add(0,1,0,0,1,32'h500,1, 0,32'h400,0,0,0,0);
        add(0,1,0,0,0,0,1,       1,32'h500,0,0,0,0);
        // reset mid-WAIT, stray rvalid ignored
`ifdef IFU_PERF_CNT_EN
        perf_idx = vecs.size();
`endif
        add(1,0,0,0,0,0,1,       0,32'h100,0,1,0,0);
        add(0,0,1,32'hBAD00000,0,0,1, 1,32'h100,0,0,0,0);
        add(0,0,0,0,0,0,1,       1,32'h100,0,1,0,0);
        add(0,1,0,0,0,0,1,       1,32'h100,0,0,0,0);
        add(0,0,1,I_A,0,0,1,     0,32'h104,0,0,0,0);
        add(0,0,0,0,0,0,1,       1,32'h104,1,1,I_A,32'h100);
        add(0,0,0,0,0,0,1,       1,32'h104,0,0,0,0);

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            @(negedge clk);
`ifdef IFU_PERF_CNT_EN
            if (i == perf_idx) begin
                chk("perf_fetch", fetch_cnt, 32'd3);
                chk("perf_drop", drop_cnt, 32'd4);
            end
`endif
            rst = v.rst; gnt = v.gnt; rv = v.rv; rdata = v.rdata;
            redir = v.redir; rpc = v.rpc; rdy = v.rdy;
            #1;
            chk($sformatf("row%0d req", i), 32'(req), 32'(v.ereq));
            chk($sformatf("row%0d addr", i), addr, v.eaddr);
            chk($sformatf("row%0d valid", i), 32'(valid), 32'(v.evalid));
            if (v.chk) begin
                chk($sformatf("row%0d instr", i), instr, v.einstr);
                chk($sformatf("row%0d pc", i), ipc, v.epc);
            end
        end

        // PC wrap and redirect alignment on the second instance
        @(negedge clk);
        rst = 1; gnt = 0; rv = 0; redir = 0; rdy = 0;
        #1;
        chk("wrap rst addr", w_addr, 32'hFFFF_FFFC);
        chk("wrap rst req", 32'(w_req), 32'd0);
        @(negedge clk);
        rst = 0; w_gnt = 1;
        #1;
        chk("wrap req1", 32'(w_req), 32'd1);
        chk("wrap addr1", w_addr, 32'hFFFF_FFFC);
        @(negedge clk);
        w_gnt = 0;
        #1;
        chk("wrap addr2", w_addr, 32'h0000_0000);
        chk("wrap wait req", 32'(w_req), 32'd0);
        w_rv = 1; w_rdata = I_G;
        @(negedge clk);
        w_rv = 0;
        #1;
        waited = 0;
        while (!w_valid && waited < 4) begin
            @(negedge clk);
            #1;
            waited++;
        end
        chk("wrap valid", 32'(w_valid), 32'd1);
        chk("wrap latency", 32'(waited), 32'd0);
        chk("wrap pc", w_ipc, 32'hFFFF_FFFC);
        chk("wrap instr", w_instr, I_G);
        w_redir = 1; w_rpc = 32'h0000_0203;
        #1;
        chk("wrap redir req", 32'(w_req), 32'd0);
        @(negedge clk);
        w_redir = 0;
        #1;
        chk("wrap redir addr", w_addr, 32'h0000_0200);
        chk("wrap redir valid", 32'(w_valid), 32'd0);
        chk("wrap redir req2", 32'(w_req), 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
